// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: ID capture fields, forwarding taps and EX outputs.
// master drives ID/forwarding side, slave is the stage itself.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [REG_AW-1:0] rs_addr_i;
  logic [REG_AW-1:0] rt_addr_i;
  logic [REG_AW-1:0] rd_addr_i;
  logic [CTRL_W-1:0] alu_ctrl_i;
  logic              alu_src_i;
  logic              reg_dst_i;
  logic              reg_write_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic              exmem_reg_write_i;
  logic [REG_AW-1:0] exmem_rd_i;
  logic [DATA_W-1:0] exmem_result_i;
  logic              memwb_reg_write_i;
  logic [REG_AW-1:0] memwb_rd_i;
  logic [DATA_W-1:0] memwb_data_i;
  logic [DATA_W-1:0] src1_o;
  logic [DATA_W-1:0] src2_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] store_data_o;
  logic [REG_AW-1:0] write_reg_o;
  logic              valid_o;
  logic              reg_write_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              load_use_o;

  modport master (
    output stall_i, flush_i, valid_i,
    output rs_data_i, rt_data_i, imm_i,
    output rs_addr_i, rt_addr_i, rd_addr_i,
    output alu_ctrl_i, alu_src_i, reg_dst_i,
    output reg_write_i, mem_read_i, mem_write_i,
    output exmem_reg_write_i, exmem_rd_i,
    output exmem_result_i,
    output memwb_reg_write_i, memwb_rd_i,
    output memwb_data_i,
    input  src1_o, src2_o, ctrl_o,
    input  store_data_o, write_reg_o,
    input  valid_o, reg_write_o,
    input  mem_read_o, mem_write_o,
    input  load_use_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i,
    input  rs_data_i, rt_data_i, imm_i,
    input  rs_addr_i, rt_addr_i, rd_addr_i,
    input  alu_ctrl_i, alu_src_i, reg_dst_i,
    input  reg_write_i, mem_read_i, mem_write_i,
    input  exmem_reg_write_i, exmem_rd_i,
    input  exmem_result_i,
    input  memwb_reg_write_i, memwb_rd_i,
    input  memwb_data_i,
    output src1_o, src2_o, ctrl_o,
    output store_data_o, write_reg_o,
    output valid_o, reg_write_o,
    output mem_read_o, mem_write_o,
    output load_use_o
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// and load-use hazard detection against the instruction in ID.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] write_reg;
  } id_ex_t;

  id_ex_t q, d;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              ex_a, wb_a;
  logic              ex_b, wb_b;

  always_ff @(posedge clk_i) begin
    if (!rst_i) q <= '0;
    else        q <= d;
  end

  // A non-valid ID slot loads the same bubble as a flush
  always_comb begin
    d = q;
    if (bus.flush_i) begin
      d = '0;
    end else if (bus.stall_i) begin
      d = q;
    end else if (!bus.valid_i) begin
      d = '0;
    end else begin
      d.valid     = 1'b1;
      d.reg_write = bus.reg_write_i;
      d.mem_read  = bus.mem_read_i;
      d.mem_write = bus.mem_write_i;
      d.alu_src   = bus.alu_src_i;
      d.alu_ctrl  = bus.alu_ctrl_i;
      d.rs_data   = bus.rs_data_i;
      d.rt_data   = bus.rt_data_i;
      d.imm       = bus.imm_i;
      d.rs        = bus.rs_addr_i;
      d.rt        = bus.rt_addr_i;
      d.write_reg = bus.reg_dst_i ? bus.rd_addr_i
                                  : bus.rt_addr_i;
    end
  end

  assign ex_a = bus.exmem_reg_write_i
             && (bus.exmem_rd_i != '0)
             && (bus.exmem_rd_i == q.rs);
  assign wb_a = bus.memwb_reg_write_i
             && (bus.memwb_rd_i != '0)
             && (bus.memwb_rd_i == q.rs);
  assign ex_b = bus.exmem_reg_write_i
             && (bus.exmem_rd_i != '0)
             && (bus.exmem_rd_i == q.rt);
  assign wb_b = bus.memwb_reg_write_i
             && (bus.memwb_rd_i != '0)
             && (bus.memwb_rd_i == q.rt);

  // EX/MEM is younger, so it beats MEM/WB
  always_comb begin
    fwd_a = q.rs_data;
    if (ex_a)      fwd_a = bus.exmem_result_i;
    else if (wb_a) fwd_a = bus.memwb_data_i;
  end

  always_comb begin
    fwd_b = q.rt_data;
    if (ex_b)      fwd_b = bus.exmem_result_i;
    else if (wb_b) fwd_b = bus.memwb_data_i;
  end

  assign bus.src1_o       = fwd_a;
  assign bus.src2_o       = q.alu_src ? q.imm : fwd_b;
  assign bus.store_data_o = fwd_b;
  assign bus.ctrl_o       = q.alu_ctrl;
  assign bus.write_reg_o  = q.write_reg;
  assign bus.valid_o      = q.valid;
  assign bus.reg_write_o  = q.reg_write;
  assign bus.mem_read_o   = q.mem_read;
  assign bus.mem_write_o  = q.mem_write;

  // rt match is deliberately not gated by alu_src_i
  assign bus.load_use_o = q.valid && q.mem_read
                       && (q.write_reg != '0)
                       && bus.valid_i
                       && ((q.write_reg == bus.rs_addr_i)
                        || (q.write_reg == bus.rt_addr_i));

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding stage directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's src1/src2/4-bit ctrl inputs plus the EX-stage control that travels downstream.
- Detects load-use hazards for the upstream stall logic.

Parameters:
DATA_W, 32, datapath width (ALU operand width)
REG_AW, 5, register-address width
CTRL_W, 4, ALU control width (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-low reset
stall_i  in  1  hold all ID/EX state this cycle
flush_i  in  1  load a bubble this cycle
valid_i  in  1  ID holds a real instruction
rs_data_i  in  DATA_W  register-file rs read data
rt_data_i  in  DATA_W  register-file rt read data
imm_i  in  DATA_W  sign-extended immediate
rs_addr_i / rt_addr_i / rd_addr_i  in  REG_AW each  register numbers
alu_ctrl_i  in  CTRL_W  ALU operation code from ALU control
alu_src_i  in  1  1: src2 = immediate
reg_dst_i  in  1  1: destination = rd, 0: destination = rt
reg_write_i / mem_read_i / mem_write_i  in  1 each  instruction control
exmem_reg_write_i  in  1  EX/MEM instruction writes a register
exmem_rd_i  in  REG_AW  EX/MEM destination
exmem_result_i  in  DATA_W  EX/MEM ALU result
memwb_reg_write_i  in  1  MEM/WB instruction writes a register
memwb_rd_i  in  REG_AW  MEM/WB destination
memwb_data_i  in  DATA_W  MEM/WB writeback data
src1_o / src2_o  out  DATA_W  ALU operands
ctrl_o  out  CTRL_W  ALU control
store_data_o  out  DATA_W  forwarded rt value for stores
write_reg_o  out  REG_AW  destination register
valid_o / reg_write_o / mem_read_o / mem_write_o  out  1 each  registered control
load_use_o  out  1  load-use hazard against the instruction currently in ID

Behaviour:
Reset (rst_i=0 at a clock edge; overrides stall_i and flush_i, including mid-stall):
- All registered fields cleared to 0.
- valid_o=0, ctrl_o=0000, write_reg_o=0, src1_o=src2_o=store_data_o=0 until the first load.

Per-edge priority: reset > flush_i > stall_i > normal load.
- flush_i=1: bubble loaded. valid, reg_write, mem_read, mem_write = 0; data, address and ctrl fields cleared to 0. Flush wins over a simultaneous stall.
- stall_i=1 (no flush): every register holds its value.
- Normal load, valid_i=1: capture all inputs. write_reg = reg_dst_i ? rd_addr_i : rt_addr_i.
- Normal load, valid_i=0: treated as a bubble, same as flush.

Forwarding (combinational on the registered rs/rt; latency 0 from registers to outputs):
- fwdA = EX/MEM result if exmem_reg_write_i && exmem_rd_i!=0 && exmem_rd_i==rs_q.
- Otherwise fwdA = MEM/WB data if memwb_reg_write_i && memwb_rd_i!=0 && memwb_rd_i==rs_q.
- Otherwise fwdA = rs_data_q.
- fwdB: same rule applied to rt_q / rt_data_q.
- EX/MEM always has priority over MEM/WB.
- Register 0 is never forwarded.
- Forwarding is re-evaluated every cycle, including while stalled.

Outputs:
- src1_o = fwdA.
- src2_o = alu_src_q ? imm_q : fwdB.
- store_data_o = fwdB, regardless of alu_src.
- ctrl_o = alu_ctrl_q, unmodified.
- Outputs remain driven when valid_o=0; downstream gates on valid_o and the control bits.

load_use_o (combinational) = valid_o && mem_read_o && write_reg_o!=0 && valid_i && (write_reg_o==rs_addr_i || write_reg_o==rt_addr_i).
- The rt match is not qualified by alu_src_i; conservative stalling is accepted.
- Upstream responds by stalling PC/IF-ID and asserting flush_i here.

Latency: ID to EX is one clock. No internal counters, so no wrap-around cases.

Test Plan:
- Reset then load: hold rst_i=0 for 2 cycles with valid_i=1, then release and load ADD (rs=3 data 5, rt=4 data 7, alu_ctrl 0010) -> valid_o=0 during reset; next cycle src1_o=5, src2_o=7, ctrl_o=0010, valid_o=1.
- Forward priority: registered rs=8. EX/MEM writes r8=0x11, MEM/WB writes r8=0x22 in the same cycle -> src1_o=0x11. Drop exmem_reg_write_i -> src1_o=0x22. Set exmem_rd_i=0 with exmem_reg_write_i=1 and memwb_rd_i=0 -> src1_o=rs_data_q.
- Immediate and store: alu_src=1, imm=0xFFFFFFFC, rt=9 forwarded from MEM/WB as 0xAB -> src2_o=0xFFFFFFFC, store_data_o=0xAB.
- Load-use: registered LW to r5 (mem_read=1, reg_dst=0, rt=5); ID presents rs=5 with valid_i=1 -> load_use_o=1. Same with ID rs=6, rt=7 -> 0. Same with ID rt=5 -> 1.
- Stall vs flush: stall_i=1 for 3 cycles while the inputs change -> outputs frozen. Assert stall_i=1 and flush_i=1 together -> next cycle valid_o=0, reg_write_o=0, ctrl_o=0000.
- Reset mid-stall: stall_i=1 with rst_i=0 at one edge -> all outputs cleared next cycle.
